// File: rtl/hex_core_mc_pkg.sv
// Shared types for the multi-cycle Hex core: opcodes, OPR functions, syscall
// codes, controller states and the instruction classes produced by decode.
package hex_pkg;

  typedef enum logic [3:0] {
    OP_LDAM = 4'h0,
    OP_LDBM = 4'h1,
    OP_STAM = 4'h2,
    OP_LDAC = 4'h3,
    OP_LDBC = 4'h4,
    OP_LDAP = 4'h5,
    OP_LDAI = 4'h6,
    OP_LDBI = 4'h7,
    OP_STAI = 4'h8,
    OP_BR   = 4'h9,
    OP_BRZ  = 4'hA,
    OP_BRN  = 4'hB,
    OP_OPR  = 4'hD,
    OP_PFIX = 4'hE,
    OP_NFIX = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    OPR_BRB = 4'h0,
    OPR_ADD = 4'h1,
    OPR_SUB = 4'h2,
    OPR_SVC = 4'h3
  } opr_t;

  typedef enum logic [7:0] {
    SYS_EXIT  = 8'd0,
    SYS_WRITE = 8'd1,
    SYS_READ  = 8'd2
  } syscall_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_EXEC,
    S_DREQ,
    S_DWAIT,
    S_SYS,
    S_HALT,
    S_TRAP
  } state_t;

  // What the controller must do with the decoded instruction.
  typedef enum logic [2:0] {
    K_REG,
    K_LOAD,
    K_STORE,
    K_SYS,
    K_TRAP
  } kind_t;

endpackage

// File: rtl/hex_core_mc_if.sv
// Fetch, data and syscall request/response bundle between the Hex core
// (master) and the memory subsystem / syscall bridge (slave).
interface hex_core_mc_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int IADDR_WIDTH   = 20,
  parameter int WADDR_WIDTH   = IADDR_WIDTH - 2,
  parameter int SYSCALL_WIDTH = 8
);

  logic                     o_f_valid;
  logic                     i_f_ready;
  logic [IADDR_WIDTH-1:0]   o_f_addr;
  logic                     i_f_rvalid;
  logic [7:0]               i_f_data;

  logic                     o_d_valid;
  logic                     i_d_ready;
  logic                     o_d_we;
  logic [WADDR_WIDTH-1:0]   o_d_addr;
  logic [DATA_WIDTH-1:0]    o_d_wdata;
  logic                     i_d_rvalid;
  logic [DATA_WIDTH-1:0]    i_d_rdata;

  logic                     o_syscall_valid;
  logic                     i_syscall_ready;
  logic [SYSCALL_WIDTH-1:0] o_syscall;
  logic [DATA_WIDTH-1:0]    o_syscall_arg;

  modport master (
    output o_f_valid, o_f_addr,
    input  i_f_ready, i_f_rvalid, i_f_data,
    output o_d_valid, o_d_we, o_d_addr, o_d_wdata,
    input  i_d_ready, i_d_rvalid, i_d_rdata,
    output o_syscall_valid, o_syscall, o_syscall_arg,
    input  i_syscall_ready
  );

  modport slave (
    input  o_f_valid, o_f_addr,
    output i_f_ready, i_f_rvalid, i_f_data,
    input  o_d_valid, o_d_we, o_d_addr, o_d_wdata,
    output i_d_ready, i_d_rvalid, i_d_rdata,
    input  o_syscall_valid, o_syscall, o_syscall_arg,
    output i_syscall_ready
  );

endinterface

// File: rtl/hex_core_mc_exec.sv
// Combinational decode/execute: from the latched instruction and the register
// file it produces every candidate next value plus the data word address.
module hex_exec
  import hex_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IADDR_WIDTH = 20,
  parameter int WADDR_WIDTH = IADDR_WIDTH - 2
) (
  input  logic [7:0]             instr,
  input  logic [IADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0]  areg,
  input  logic [DATA_WIDTH-1:0]  breg,
  input  logic [DATA_WIDTH-1:0]  oreg,
  output logic [IADDR_WIDTH-1:0] pc_seq,
  output logic [IADDR_WIDTH-1:0] pc_next,
  output logic [DATA_WIDTH-1:0]  areg_next,
  output logic [DATA_WIDTH-1:0]  breg_next,
  output logic [DATA_WIDTH-1:0]  oreg_next,
  output logic [WADDR_WIDTH-1:0] d_addr,
  output kind_t                  kind,
  output logic                   load_to_a
);

  opcode_t                op;
  logic [DATA_WIDTH-1:0]  opr;
  logic [IADDR_WIDTH-1:0] pc_rel;

  assign op     = opcode_t'(instr[7:4]);
  assign opr    = oreg | DATA_WIDTH'(instr[3:0]);
  assign pc_seq = pc + IADDR_WIDTH'(1);
  assign pc_rel = pc_seq + IADDR_WIDTH'(opr);

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    pc_next   = pc_seq;
    areg_next = areg;
    breg_next = breg;
    oreg_next = '0;
    d_addr    = WADDR_WIDTH'(opr);
    kind      = K_REG;
    load_to_a = 1'b0;
    case (op)
      OP_LDAM: begin kind = K_LOAD; load_to_a = 1'b1; end
      OP_LDBM: kind = K_LOAD;
      OP_STAM: kind = K_STORE;
      OP_LDAC: areg_next = opr;
      OP_LDBC: breg_next = opr;
      OP_LDAP: areg_next = DATA_WIDTH'(pc) + DATA_WIDTH'(1) + opr;
      OP_LDAI: begin
        kind      = K_LOAD;
        load_to_a = 1'b1;
        d_addr    = WADDR_WIDTH'(areg + opr);
      end
      OP_LDBI: begin kind = K_LOAD;  d_addr = WADDR_WIDTH'(breg + opr); end
      OP_STAI: begin kind = K_STORE; d_addr = WADDR_WIDTH'(breg + opr); end
      OP_BR:   pc_next = pc_rel;
      OP_BRZ:  if (areg == '0) pc_next = pc_rel;
      OP_BRN:  if (areg[DATA_WIDTH-1]) pc_next = pc_rel;
      OP_OPR: begin
        // A prefixed operand above the last defined function is illegal too.
        if (opr[DATA_WIDTH-1:4] != '0) begin
          kind = K_TRAP;
        end else begin
          case (opr_t'(opr[3:0]))
            OPR_BRB: pc_next   = IADDR_WIDTH'(breg);
            OPR_ADD: areg_next = areg + breg;
            OPR_SUB: areg_next = areg - breg;
            OPR_SVC: kind      = K_SYS;
            default: kind      = K_TRAP;
          endcase
        end
      end
      OP_PFIX: oreg_next = opr << 4;
      OP_NFIX: oreg_next = ({DATA_WIDTH{1'b1}} << 8) | (opr << 4);
      default: kind = K_TRAP;
    endcase
  end

endmodule

// File: rtl/hex_core_mc.sv
// Multi-cycle Hex core: one request in flight at a time on the fetch, data or
// syscall port; halts on exit syscall, traps on illegal instructions.
module hex_core_mc
  import hex_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IADDR_WIDTH   = 20,
  parameter int WADDR_WIDTH   = IADDR_WIDTH - 2,
  parameter int SYSCALL_WIDTH = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  hex_core_mc_if.master        bus,
  output logic                 o_halted,
  output logic                 o_trap,
  output logic [CNT_WIDTH-1:0] o_instr_count
);

  state_t                 state, state_next;
  logic [IADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0]  areg, breg, oreg;
  logic [7:0]             instr;
  logic [CNT_WIDTH-1:0]   count;

  logic [IADDR_WIDTH-1:0] pc_seq, pc_next;
  logic [DATA_WIDTH-1:0]  areg_next, breg_next, oreg_next;
  logic [WADDR_WIDTH-1:0] d_addr;
  kind_t                  kind;
  logic                   load_to_a;

  logic instr_we, exec_commit, retire, load_we;
  logic f_valid, d_valid, d_we, sys_valid;
  logic sys_exit;

  hex_exec #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IADDR_WIDTH (IADDR_WIDTH),
    .WADDR_WIDTH (WADDR_WIDTH)
  ) u_exec (
    .instr     (instr),
    .pc        (pc),
    .areg      (areg),
    .breg      (breg),
    .oreg      (oreg),
    .pc_seq    (pc_seq),
    .pc_next   (pc_next),
    .areg_next (areg_next),
    .breg_next (breg_next),
    .oreg_next (oreg_next),
    .d_addr    (d_addr),
    .kind      (kind),
    .load_to_a (load_to_a)
  );

  assign sys_exit = (areg[SYSCALL_WIDTH-1:0] == SYSCALL_WIDTH'(SYS_EXIT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_we    = 1'b0;
    exec_commit = 1'b0;
    retire      = 1'b0;
    load_we     = 1'b0;
    f_valid     = 1'b0;
    d_valid     = 1'b0;
    d_we        = 1'b0;
    sys_valid   = 1'b0;
    case (state)
      S_FETCH: begin
        f_valid = 1'b1;
        if (bus.i_f_ready) state_next = S_FWAIT;
      end
      S_FWAIT: begin
        if (bus.i_f_rvalid) begin
          instr_we   = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind)
          K_REG: begin
            exec_commit = 1'b1;
            retire      = 1'b1;
            state_next  = S_FETCH;
          end
          K_LOAD, K_STORE: state_next = S_DREQ;
          K_SYS:           state_next = S_SYS;
          default:         state_next = S_TRAP;
        endcase
      end
      S_DREQ: begin
        d_valid = 1'b1;
        d_we    = (kind == K_STORE);
        if (bus.i_d_ready) begin
          retire     = d_we;
          state_next = d_we ? S_FETCH : S_DWAIT;
        end
      end
      S_DWAIT: begin
        if (bus.i_d_rvalid) begin
          load_we    = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_SYS: begin
        sys_valid = 1'b1;
        if (bus.i_syscall_ready) begin
          retire     = 1'b1;
          state_next = sys_exit ? S_HALT : S_FETCH;
        end
      end
      default: state_next = state;
    endcase
  end

  // Registers stay untouched until the instruction retires, so decode outputs
  // (data address, store data) remain stable for the whole request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc    <= '0;
      areg  <= '0;
      breg  <= '0;
      oreg  <= '0;
      instr <= '0;
      count <= '0;
    end else begin
      if (instr_we) instr <= bus.i_f_data;
      if (exec_commit) begin
        pc   <= pc_next;
        areg <= areg_next;
        breg <= breg_next;
        oreg <= oreg_next;
      end else if (retire) begin
        pc   <= pc_seq;
        oreg <= '0;
      end
      if (load_we) begin
        if (load_to_a) areg <= bus.i_d_rdata;
        else           breg <= bus.i_d_rdata;
      end
      if (retire) count <= count + CNT_WIDTH'(1);
    end
  end

  // NOTE: state resets to FETCH, so valids are masked by the reset input to
  // keep all requests low while reset is held.
  assign bus.o_f_valid       = f_valid & i_rst_n;
  assign bus.o_f_addr        = pc;
  assign bus.o_d_valid       = d_valid & i_rst_n;
  assign bus.o_d_we          = d_we;
  assign bus.o_d_addr        = d_addr;
  assign bus.o_d_wdata       = areg;
  assign bus.o_syscall_valid = sys_valid & i_rst_n;
  assign bus.o_syscall       = areg[SYSCALL_WIDTH-1:0];
  assign bus.o_syscall_arg   = breg;

  assign o_halted      = (state == S_HALT);
  assign o_trap        = (state == S_TRAP);
  assign o_instr_count = count;

endmodule

// File: tb/tb_hex_core_mc.sv
// Directed test of hex_core_mc against a behavioural memory / syscall
// environment with programmable stall and response latency.
module tb_hex_core_mc;
  import hex_pkg::*;

  localparam int DW = 32;
  localparam int IW = 20;
  localparam int WW = IW - 2;
  localparam int SW = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_core_mc_if #(.DATA_WIDTH(DW), .IADDR_WIDTH(IW), .WADDR_WIDTH(WW),
                   .SYSCALL_WIDTH(SW)) bus ();

  logic          halted, trap;
  logic [CW-1:0] instr_count;

  hex_core_mc #(
    .DATA_WIDTH (DW), .IADDR_WIDTH (IW), .WADDR_WIDTH (WW),
    .SYSCALL_WIDTH (SW), .CNT_WIDTH (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .o_halted      (halted),
    .o_trap        (trap),
    .o_instr_count (instr_count)
  );

  logic [7:0]    imem [256];
  logic [DW-1:0] dmem [64];

  // Environment knobs and state
  int d_stall, d_lat, sys_delay;
  int d_stall_cnt, d_resp_cnt, sys_cnt;
  logic          f_pend;
  logic [IW-1:0] f_addr_q;
  logic [WW-1:0] d_addr_q;
  logic          load_busy;

  // Monitors
  int stall_cycles, hold_bad, fetch_in_load, fetch_in_halt, sys_n;
  logic          d_pend_prev;
  logic [WW-1:0] prev_addr;
  logic          prev_we;
  logic [DW-1:0] prev_wdata;
  logic [WW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [SW-1:0] sys_code [2];
  logic [DW-1:0] sys_arg  [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory and syscall responder; drives inputs on the falling edge.
  initial begin
    bus.i_f_ready = 1'b1; bus.i_f_rvalid = 1'b0; bus.i_f_data = '0;
    bus.i_d_ready = 1'b0; bus.i_d_rvalid = 1'b0; bus.i_d_rdata = '0;
    bus.i_syscall_ready = 1'b0;
    f_pend = 1'b0; load_busy = 1'b0; d_pend_prev = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_f_rvalid = 1'b0;
      bus.i_d_rvalid = 1'b0;
      if (!rst_n) begin
        f_pend = 1'b0; d_resp_cnt = 0; load_busy = 1'b0; d_pend_prev = 1'b0;
        bus.i_d_ready = 1'b0; bus.i_syscall_ready = 1'b0;
        d_stall_cnt = d_stall; sys_cnt = sys_delay;
      end else begin
        if (f_pend) begin
          bus.i_f_rvalid = 1'b1;
          bus.i_f_data   = imem[f_addr_q[7:0]];
          f_pend = 1'b0;
        end
        if (bus.o_f_valid && bus.i_f_ready) begin
          f_pend = 1'b1; f_addr_q = bus.o_f_addr;
        end
        if (bus.o_f_valid && load_busy) fetch_in_load++;
        if (bus.o_f_valid && halted)    fetch_in_halt++;

        if (d_resp_cnt > 0) begin
          d_resp_cnt--;
          if (d_resp_cnt == 0) begin
            bus.i_d_rvalid = 1'b1;
            bus.i_d_rdata  = dmem[d_addr_q[5:0]];
            load_busy = 1'b0;
          end
        end
        bus.i_d_ready = 1'b0;
        if (bus.o_d_valid) begin
          if (d_pend_prev && (bus.o_d_addr != prev_addr || bus.o_d_we != prev_we ||
                              bus.o_d_wdata != prev_wdata)) hold_bad++;
          d_pend_prev = 1'b1;
          prev_addr = bus.o_d_addr; prev_we = bus.o_d_we; prev_wdata = bus.o_d_wdata;
          if (d_stall_cnt > 0) begin
            d_stall_cnt--; stall_cycles++;
          end else begin
            bus.i_d_ready = 1'b1; d_stall_cnt = d_stall; d_pend_prev = 1'b0;
            if (bus.o_d_we) begin
              dmem[bus.o_d_addr[5:0]] = bus.o_d_wdata;
              st_addr = bus.o_d_addr; st_data = bus.o_d_wdata;
            end else begin
              d_resp_cnt = d_lat; d_addr_q = bus.o_d_addr; load_busy = 1'b1;
            end
          end
        end else if (d_pend_prev) begin
          hold_bad++;
          d_pend_prev = 1'b0;
        end

        bus.i_syscall_ready = 1'b0;
        if (bus.o_syscall_valid) begin
          if (sys_cnt > 0) sys_cnt--;
          else begin
            bus.i_syscall_ready = 1'b1; sys_cnt = sys_delay;
            if (sys_n < 2) begin
              sys_code[sys_n] = bus.o_syscall; sys_arg[sys_n] = bus.o_syscall_arg;
            end
            sys_n++;
          end
        end
      end
    end
  end

  task automatic clear_mon();
    stall_cycles = 0; hold_bad = 0; fetch_in_load = 0; fetch_in_halt = 0; sys_n = 0;
  endtask

  task automatic prep(input logic [7:0] prog [$]);
    for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
    for (int i = 0; i < 64; i++)  dmem[i] = '0;
    foreach (prog[i]) imem[i] = prog[i];
  endtask

  // Leaves time at posedge+2 with reset released; next posedge is cycle 1.
  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 clear_mon();
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_stop(input string tag, input int budget);
    int k = 0;
    while (!(halted || trap) && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_stopped"}, 64'(halted || trap), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [$];
    d_stall = 0; d_lat = 1; sys_delay = 0;
    clear_mon();

    // Reset state
    #12;
    check("rst_f_valid",   64'(bus.o_f_valid), 64'd0);
    check("rst_d_valid",   64'(bus.o_d_valid), 64'd0);
    check("rst_sys_valid", 64'(bus.o_syscall_valid), 64'd0);
    check("rst_count",     64'(instr_count), 64'd0);
    check("rst_halted",    64'(halted), 64'd0);
    check("rst_trap",      64'(trap), 64'd0);

    // LDAC 5, LDBC 3, ADD; prefix and negative-prefix constants
    q = {8'h35, 8'h43, 8'hD1, 8'h20, 8'hEF, 8'h3F, 8'h21, 8'hF0, 8'h31, 8'h22};
    prep(q);
    do_reset();
    cycles(9);
    check("cpi3_count9", 64'(instr_count), 64'd3);
    wait_stop("prog1", 200);
    check("prog1_trap",   64'(trap), 64'd1);
    check("prog1_halted", 64'(halted), 64'd0);
    check("prog1_count",  64'(instr_count), 64'd10);
    check("add_result",   64'(dmem[0]), 64'h8);
    check("pfix_const",   64'(dmem[1]), 64'hFF);
    check("nfix_const",   64'(dmem[2]), 64'hFFFF_FF01);
    cycles(3);
    check("trap_no_fetch", 64'(bus.o_f_valid), 64'd0);

    // STAM 4 with the data port stalled for 5 cycles
    q = {8'h37, 8'h24};
    prep(q);
    d_stall = 5;
    do_reset();
    cycles(11);
    check("st_stalled_count", 64'(instr_count), 64'd1);
    check("st_valid_held",    64'(bus.o_d_valid), 64'd1);
    cycles(1);
    check("st_retire_on_acc", 64'(instr_count), 64'd2);
    wait_stop("store", 100);
    check("st_mem",          64'(dmem[4]), 64'h7);
    check("st_addr",         64'(st_addr), 64'd4);
    check("st_wdata",        64'(st_data), 64'h7);
    check("st_stall_cycles", 64'(stall_cycles), 64'd5);
    check("st_hold_stable",  64'(hold_bad), 64'd0);
    d_stall = 0;

    // LDAM 2 with a 7-cycle response
    q = {8'h02, 8'h25};
    prep(q);
    dmem[2] = 32'h1234;
    d_lat = 7;
    do_reset();
    cycles(10);
    check("ld_wait_count",    64'(instr_count), 64'd0);
    cycles(1);
    check("ld_retire_count",  64'(instr_count), 64'd1);
    wait_stop("load", 100);
    check("ld_value",         64'(dmem[5]), 64'h1234);
    check("ld_no_fetch",      64'(fetch_in_load), 64'd0);
    check("ld_count",         64'(instr_count), 64'd2);
    d_lat = 1;

    // WRITE syscall then EXIT syscall, each serviced after 3 cycles
    q = {8'h46, 8'h31, 8'hD3, 8'h30, 8'hD3, 8'h35, 8'h20};
    prep(q);
    sys_delay = 3;
    do_reset();
    wait_stop("sys", 200);
    check("sys_halted",   64'(halted), 64'd1);
    check("sys_trap",     64'(trap), 64'd0);
    check("sys_count",    64'(instr_count), 64'd5);
    check("sys_n",        64'(sys_n), 64'd2);
    check("sys0_code",    64'(sys_code[0]), 64'd1);
    check("sys0_arg",     64'(sys_arg[0]), 64'd6);
    check("sys1_code",    64'(sys_code[1]), 64'd0);
    cycles(10);
    check("halt_count_frozen", 64'(instr_count), 64'd5);
    check("halt_no_fetch",     64'(fetch_in_halt), 64'd0);
    check("halt_f_valid",      64'(bus.o_f_valid), 64'd0);
    check("halt_mem_clean",    64'(dmem[0]), 64'd0);
    sys_delay = 0;

    // BRZ taken, LDAP, BRN not taken
    q = {8'h30, 8'hA2, 8'h3E, 8'h3E, 8'h52, 8'h20, 8'hB2, 8'hC0, 8'hC0, 8'h21};
    prep(q);
    do_reset();
    wait_stop("branch", 200);
    check("brz_ldap_value", 64'(dmem[0]), 64'h7);
    check("brn_not_taken",  64'(dmem[1]), 64'h0);
    check("branch_count",   64'(instr_count), 64'd5);

    // Reset asserted while a load is outstanding
    q = {8'h33, 8'h01};
    prep(q);
    dmem[1] = 32'hABCD;
    d_lat = 20;
    do_reset();
    cycles(9);
    check("dwait_count",   64'(instr_count), 64'd1);
    check("dwait_f_valid", 64'(bus.o_f_valid), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_count",   64'(instr_count), 64'd0);
    check("mid_rst_f_valid", 64'(bus.o_f_valid), 64'd0);
    check("mid_rst_d_valid", 64'(bus.o_d_valid), 64'd0);
    q = {8'h20};
    prep(q);
    dmem[0] = 32'h55;
    d_lat = 1;
    repeat (2) @(posedge clk);
    #2 clear_mon();
    rst_n = 1'b1;
    #1;
    check("post_rst_f_valid", 64'(bus.o_f_valid), 64'd1);
    check("post_rst_f_addr",  64'(bus.o_f_addr), 64'd0);
    wait_stop("post_rst", 100);
    check("post_rst_areg0", 64'(dmem[0]), 64'd0);
    check("illegal_trap",   64'(trap), 64'd1);
    check("illegal_count",  64'(instr_count), 64'd1);
    cycles(5);
    check("trap_count_frozen", 64'(instr_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
